// File: rtl/booth_pkg.sv
// Shared constants and radix-4 Booth recoding for booth_multiplier_routing.
// Optional output register is enabled by defining BOOTH_OUT_REG_EN.
package booth_pkg;

    localparam int unsigned BOOTH_WIDTH = 16;

    typedef enum logic [2:0] {
        ZERO,
        POS1,
        POS2,
        NEG1,
        NEG2
    } booth_digit_t;

    // Window is {b[2i+1], b[2i], b[2i-1]}.
    function automatic booth_digit_t booth_recode(input logic [2:0] win);
        booth_digit_t d;
        case (win)
            3'b001, 3'b010: d = POS1;
            3'b011:         d = POS2;
            3'b100:         d = NEG2;
            3'b101, 3'b110: d = NEG1;
            default:        d = ZERO;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/booth_pp_gen.sv
// One Booth partial product: digit*A sign-extended to 2*WIDTH bits, shifted by 2*IDX.
// Negative digits emit the one's complement; the +1 is returned as corr for bit 2*IDX.
module booth_pp_gen
    import booth_pkg::*;
#(
    parameter int unsigned WIDTH = BOOTH_WIDTH,
    parameter int unsigned IDX   = 0
) (
    input  logic [WIDTH-1:0]   a,
    input  booth_digit_t       digit,
    output logic [2*WIDTH-1:0] pp,
    output logic               corr
);

    logic [2*WIDTH-1:0] ext;
    logic [2*WIDTH-1:0] mag;
    logic               neg;

    always_comb begin
        // Doubling in full 2*WIDTH precision keeps -2^(WIDTH-1) exact.
        ext = {{WIDTH{a[WIDTH-1]}}, a};
        mag = '0;
        neg = 1'b0;
        case (digit)
            POS1: mag = ext;
            POS2: mag = ext << 1;
            NEG1: begin
                mag = ext;
                neg = 1'b1;
            end
            NEG2: begin
                mag = ext << 1;
                neg = 1'b1;
            end
            default: mag = '0;
        endcase
        pp   = (neg ? ~mag : mag) << (2 * IDX);
        corr = neg;
    end

endmodule

// File: rtl/booth_multiplier_routing.sv
// Radix-4 Booth signed multiplier: WIDTH/2 partial products plus a correction word,
// reduced by an unrolled carry-save tree and one final adder. BOOTH_OUT_REG_EN registers product.
module booth_multiplier_routing
    import booth_pkg::*;
#(
    parameter int unsigned WIDTH = BOOTH_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic [2*WIDTH-1:0]   product
);

    localparam int unsigned NDIG = WIDTH / 2;
    localparam int unsigned NOPS = NDIG + 1;

    function automatic int unsigned reduce_cnt(input int unsigned n);
        return (n / 3) * 2 + (n % 3);
    endfunction

    function automatic int unsigned count_at(input int unsigned lvl);
        int unsigned n;
        n = NOPS;
        for (int unsigned k = 0; k < lvl; k++) n = reduce_cnt(n);
        return n;
    endfunction

    function automatic int unsigned num_levels();
        int unsigned n;
        int unsigned l;
        n = NOPS;
        l = 0;
        while (n > 2) begin
            n = reduce_cnt(n);
            l++;
        end
        return l;
    endfunction

    localparam int unsigned LEVELS = num_levels();

    logic [WIDTH:0]       b_ext;
    logic [NDIG-1:0]      corr;
    logic [2*WIDTH-1:0]   cvec;
    logic [2*WIDTH-1:0]   lvl [0:LEVELS][0:NOPS-1];
    logic [2*WIDTH-1:0]   sum;

    assign b_ext = {multiplier, 1'b0};

    for (genvar i = 0; i < NDIG; i++) begin : g_pp
        booth_pp_gen #(
            .WIDTH (WIDTH),
            .IDX   (i)
        ) u_pp (
            .a     (multiplicand),
            .digit (booth_recode(b_ext[2*i+2 -: 3])),
            .pp    (lvl[0][i]),
            .corr  (corr[i])
        );
    end

    // Correction bits sit at distinct even positions, so they share one operand word.
    always_comb begin
        cvec = '0;
        for (int unsigned i = 0; i < NDIG; i++) cvec[2*i] = corr[i];
    end

    assign lvl[0][NDIG] = cvec;

    for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
        localparam int unsigned CNT  = count_at(l);
        localparam int unsigned NGRP = CNT / 3;
        localparam int unsigned NXT  = reduce_cnt(CNT);

        for (genvar g = 0; g < NGRP; g++) begin : g_csa
            logic [2*WIDTH-1:0] x, y, z;
            assign x = lvl[l][3*g];
            assign y = lvl[l][3*g+1];
            assign z = lvl[l][3*g+2];
            assign lvl[l+1][2*g]   = x ^ y ^ z;
            assign lvl[l+1][2*g+1] = ((x & y) | (x & z) | (y & z)) << 1;
        end

        for (genvar r = 0; r < CNT % 3; r++) begin : g_pass
            assign lvl[l+1][2*NGRP+r] = lvl[l][3*NGRP+r];
        end

        for (genvar u = NXT; u < NOPS; u++) begin : g_idle
            assign lvl[l+1][u] = '0;
        end
    end

    assign sum = lvl[LEVELS][0] + lvl[LEVELS][1];

`ifdef BOOTH_OUT_REG_EN
    always_ff @(posedge clk) begin
        if (rst) product <= '0;
        else     product <= sum;
    end
`else
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign product = sum;
`endif

endmodule

// File: tb/tb_booth_multiplier_routing.sv
// Directed self-checking bench for booth_multiplier_routing (both BOOTH_OUT_REG_EN builds).
module tb_booth_multiplier_routing;

    localparam int unsigned W = 16;

    logic             clk;
    logic             rst;
    logic [W-1:0]     multiplicand;
    logic [W-1:0]     multiplier;
    logic [2*W-1:0]   product;

    int unsigned n_checks;
    int unsigned n_pass;

    booth_multiplier_routing #(
        .WIDTH (W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .product      (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
`ifdef BOOTH_OUT_REG_EN
        @(negedge clk);
        rst          = 1'b1;
        multiplicand = 16'd3;
        multiplier   = 16'd4;
        @(posedge clk);
        @(posedge clk);
        #1;
        n_checks++;
        if (product !== 32'h0) $display("FAIL reset_hold: got %h want %h", product, 32'h0);
        else n_pass++;
`else
        rst          = 1'b1;
        multiplicand = 16'd3;
        multiplier   = 16'd4;
        #20;
        n_checks++;
        if (product !== 32'd12) $display("FAIL reset_ignored: got %h want %h", product, 32'd12);
        else n_pass++;
`endif
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_vec(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [2*W-1:0] want);
        @(negedge clk);
        multiplicand = a;
        multiplier   = b;
        #20;
        n_checks++;
        if (product !== want)
            $display("FAIL %s: A=%h B=%h got %h want %h", name, a, b, product, want);
        else n_pass++;
    endtask

    task automatic test_unsigned();
        run_vec("zero_a",  16'd0,   16'd5,  32'd0);
        run_vec("u100x12", 16'd100, 16'd12, 32'd1200);
        run_vec("u90x4",   16'd90,  16'd4,  32'd360);
        run_vec("u85x30",  16'd85,  16'd30, 32'd2550);
        run_vec("zero_b",  16'h8000, 16'd0, 32'd0);
    endtask

    task automatic test_signed();
        run_vec("m3x7",  16'hFFFD, 16'd7,    32'hFFFF_FFEB);
        run_vec("7xm3",  16'd7,    16'hFFFD, 32'hFFFF_FFEB);
        run_vec("m1xm1", 16'hFFFF, 16'hFFFF, 32'h0000_0001);
    endtask

    task automatic test_extremes();
        run_vec("minxmin", 16'h8000, 16'h8000, 32'h4000_0000);
        run_vec("maxxmin", 16'h7FFF, 16'h8000, 32'hC000_8000);
        run_vec("minxmax", 16'h8000, 16'h7FFF, 32'hC000_8000);
    endtask

    task automatic test_booth_boundary();
        run_vec("b5555", 16'd1, 16'h5555, 32'h0000_5555);
        run_vec("bAAAA", 16'd1, 16'hAAAA, 32'hFFFF_AAAA);
        run_vec("bFFFF", 16'd1, 16'hFFFF, 32'hFFFF_FFFF);
        run_vec("b8000", 16'd1, 16'h8000, 32'hFFFF_8000);
    endtask

`ifdef BOOTH_OUT_REG_EN
    task automatic test_out_reg();
        @(negedge clk);
        multiplicand = 16'd100;
        multiplier   = 16'd12;
        @(posedge clk);
        #1;
        n_checks++;
        if (product !== 32'd1200) $display("FAIL reg_load: got %h want %h", product, 32'd1200);
        else n_pass++;

        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (product !== 32'h0) $display("FAIL reg_reset: got %h want %h", product, 32'h0);
        else n_pass++;

        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (product !== 32'd1200) $display("FAIL reg_release: got %h want %h", product, 32'd1200);
        else n_pass++;

        @(negedge clk);
        multiplicand = 16'hFFFD;
        multiplier   = 16'd7;
        @(posedge clk);
        #1;
        n_checks++;
        if (product !== 32'hFFFF_FFEB) $display("FAIL reg_next: got %h want %h", product, 32'hFFFF_FFEB);
        else n_pass++;
    endtask
`endif

    initial begin
        n_checks     = 0;
        n_pass       = 0;
        rst          = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        test_reset();
        test_unsigned();
        test_signed();
        test_extremes();
        test_booth_boundary();
`ifdef BOOTH_OUT_REG_EN
        test_out_reg();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/booth_multiplier_routing.md
BOOTH_MULTIPLIER_ROUTING -- requirements
Module: booth_multiplier_routing

Interface
REQ-001 Parameter WIDTH, default 16: operand width in bits; SHALL be even and >= 4.
REQ-002 Port clk, input, 1: the single clock; all sequential logic SHALL be on its rising edge.
REQ-003 Port rst, input, 1: reset, synchronous and active-high.
REQ-004 Port multiplicand, input, WIDTH: two's-complement operand A.
REQ-005 Port multiplier, input, WIDTH: two's-complement operand B; this operand is Booth-recoded.
REQ-006 Port product, output, 2*WIDTH: two's-complement A*B.

Function
REQ-007 product SHALL equal the exact signed product A*B over the full 2*WIDTH bits; overflow is impossible.
- Example: -32768 * -32768 = 32'h4000_0000.
REQ-008 Multiplication SHALL use radix-4 modified Booth recoding of multiplier.
- WIDTH/2 digits in {-2,-1,0,+1,+2}.
- Digit i is formed from bits {B[2i+1], B[2i], B[2i-1]}, with B[-1]=0.
REQ-009 Partial product i SHALL be digit_i*A, sign-extended to 2*WIDTH bits and shifted left by 2i.
- -A and -2A SHALL be formed as one's complement plus a correction 1 added at bit 2i.
REQ-010 Routing: partial products SHALL be summed by a carry-save adder tree, followed by one final carry-propagate adder.
- The tree is combinational, fully unrolled and has no internal state.
REQ-011 Without BOOTH_OUT_REG_EN, product SHALL be purely combinational in multiplicand and multiplier (zero-cycle latency).
- clk and rst are unused in this case.
- product SHALL be valid within one clock period or within 20 time units of an input change in simulation.
REQ-012 Operand 0 on either input SHALL yield product 0; the digit 0 partial product is all zeros with no correction bit.
REQ-013 Most-negative operands SHALL be handled exactly.
- A = -2^(WIDTH-1): -2A is formed in 2*WIDTH-bit precision, not in WIDTH bits.
- B = -2^(WIDTH-1): recodes to a top digit of -2.
REQ-014 The block SHALL be stateless apart from the optional output register; there is no handshake and no busy state.

Reset
REQ-015 With BOOTH_OUT_REG_EN, rst high at a rising clk edge SHALL clear the product register to 0.
- Reset overrides the new input sample on that edge.
REQ-016 Reset released mid-stream: the first edge with rst low SHALL load the product of the inputs present at that edge.
REQ-017 Without BOOTH_OUT_REG_EN, rst SHALL have no effect; product follows the inputs at all times.

Configuration
REQ-018 Macro BOOTH_OUT_REG_EN, when defined: product SHALL be registered.
- Latency is 1 clk cycle, with a new result every cycle.
- The register's reset value is 0.
REQ-019 When BOOTH_OUT_REG_EN is undefined: the output register SHALL be absent and product is driven combinationally (REQ-011).

Structure
REQ-020 Shared package booth_pkg SHALL hold:
- the default WIDTH constant (16);
- the enum typedef booth_digit_t {ZERO, POS1, POS2, NEG1, NEG2};
- the recoding function from a 3-bit window to booth_digit_t.
REQ-021 One sub-module, booth_pp_gen, SHALL map (A, booth_digit_t) to the 2*WIDTH-bit shifted partial product plus its correction bit.
- It is instantiated WIDTH/2 times.
- The adder tree stays in the top module.

Verification
REQ-022 Unsigned-range products SHALL be checked; each is a combinational check 20 time units after applying the inputs:
- A=0, B=5 -> product=0
- A=100, B=12 -> product=1200
- A=90, B=4 -> product=360
- A=85, B=30 -> product=2550
REQ-023 Signed products SHALL be checked:
- A=-3, B=7 -> 32'hFFFF_FFEB (-21)
- A=7, B=-3 -> 32'hFFFF_FFEB (-21)
- A=-1, B=-1 -> 1
REQ-024 Extremes SHALL be checked:
- A=-32768, B=-32768 -> 32'h4000_0000
- A=32767, B=-32768 -> 32'hC000_8000
REQ-025 Booth-boundary multipliers SHALL be checked with A=1: B=16'h5555, 16'hAAAA, 16'hFFFF, 16'h8000 -> product equals the sign-extended B.
REQ-026 With BOOTH_OUT_REG_EN defined:
- Hold rst high for 2 edges -> product=0.
- Release rst; apply A=100, B=12 -> product=1200 one edge later.
- Assert rst for one edge with the same inputs -> product=0 on that edge.
